// File: rtl/nes_bus_pkg.sv
// Shared NES system-bus constants and the OAM sprite-DMA state encoding.
package nes_bus_pkg;

  localparam logic [15:0] PPU_BASE      = 16'h2000;
  localparam logic [15:0] OAM_DATA_ADDR = PPU_BASE + 16'h0004;
  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dmaState_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA engine: snoops CPU writes to the DMA register, stalls the CPU and
// copies one page of memory into the PPU OAM data port as read/write pairs.
module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = nes_bus_pkg::DMA_REG_ADDR,
  parameter logic [15:0] OAM_DATA_ADDR = nes_bus_pkg::OAM_DATA_ADDR,
  parameter int unsigned XFER_LEN      = 256
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_dout,
  input  logic        cpu_r_nw,
  input  logic [7:0]  bus_din,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_dout,
  output logic        bus_r_nw,
  output logic        cpu_rdy,
  output logic        dma_active
);

  import nes_bus_pkg::*;

  // XFER_LEN is a power of two, so masking gives the wrap and the end index.
  localparam logic [7:0] IDX_MASK = 8'(XFER_LEN - 1);

  dmaState_t  r_state;
  logic [7:0] r_idx;
  logic [7:0] r_page;
  logic [7:0] r_dataQ;
  logic       r_parity;

  logic       w_trigger;
  logic       w_dmaActive;

  assign w_trigger   = !cpu_r_nw && (cpu_addr == DMA_REG_ADDR);
  assign w_dmaActive = (r_state != IDLE);

  // Parity free-runs so READ always lands on a get cycle; HALT inserts ALIGN
  // when it would otherwise put the first READ on a put cycle.
  always_ff @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_idx    <= '0;
      r_page   <= '0;
      r_dataQ  <= '0;
      r_parity <= 1'b0;
    end else begin
      r_parity <= ~r_parity;
      case (r_state)
        IDLE: begin
          if (w_trigger) begin
            r_page  <= cpu_dout;
            r_idx   <= '0;
            r_state <= HALT;
          end
        end
        HALT:  r_state <= r_parity ? READ : ALIGN;
        ALIGN: r_state <= READ;
        READ: begin
          r_dataQ <= bus_din;
          r_state <= WRITE;
        end
        WRITE: begin
          r_idx   <= (r_idx + 8'd1) & IDX_MASK;
          r_state <= (r_idx == IDX_MASK) ? IDLE : READ;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Idle passes the CPU straight through; otherwise the engine owns the bus.
  always_comb begin
    bus_addr = cpu_addr;
    bus_dout = cpu_dout;
    bus_r_nw = cpu_r_nw;
    case (r_state)
      HALT, ALIGN: begin
        bus_addr = {r_page, 8'h00};
        bus_dout = r_dataQ;
        bus_r_nw = 1'b1;
      end
      READ: begin
        bus_addr = {r_page, r_idx};
        bus_dout = r_dataQ;
        bus_r_nw = 1'b1;
      end
      WRITE: begin
        bus_addr = OAM_DATA_ADDR;
        bus_dout = r_dataQ;
        bus_r_nw = 1'b0;
      end
      default: ;
    endcase
  end

  assign dma_active = w_dmaActive;
  assign cpu_rdy    = ~w_dmaActive;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a cycle-list model of each transfer plus
// literal checks on stall length, OAM contents and reset behaviour.
module tb_oam_dma;

  logic        clk_ph1 = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_dout;
  logic        cpu_r_nw;
  logic [7:0]  bus_din;
  logic [15:0] bus_addr;
  logic [7:0]  bus_dout;
  logic        bus_r_nw;
  logic        cpu_rdy;
  logic        dma_active;

  logic [7:0] mem [0:65535];
  assign bus_din = mem[bus_addr];

  always #5 clk_ph1 = ~clk_ph1;

  oam_dma dut (
    .clk_ph1   (clk_ph1),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_r_nw  (cpu_r_nw),
    .bus_din   (bus_din),
    .bus_addr  (bus_addr),
    .bus_dout  (bus_dout),
    .bus_r_nw  (bus_r_nw),
    .cpu_rdy   (cpu_rdy),
    .dma_active(dma_active)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rnw;
    logic [7:0]  data;
    bit          chkData;
  } busCycle_t;

  busCycle_t  expQ[$];
  int         modelCycle = 0;
  int         vectorCount = 0;
  int         missCount = 0;
  logic [7:0] oamLog[$];
  int         lowRun = 0;
  int         lastStall = 0;
  int         page00Reads = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectorCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Expected bus cycles of one whole transfer, from the trigger page and the
  // parity of the cycle right after the trigger.
  task automatic buildTransfer(input logic [7:0] page, input int haltParity);
    busCycle_t c;
    c = '{addr: {page, 8'h00}, rnw: 1'b1, data: 8'h00, chkData: 1'b0};
    expQ.push_back(c);
    if (haltParity == 0) expQ.push_back(c);
    for (int i = 0; i < 256; i++) begin
      c = '{addr: {page, 8'(i)}, rnw: 1'b1, data: 8'h00, chkData: 1'b0};
      expQ.push_back(c);
      c = '{addr: 16'h2004, rnw: 1'b0, data: mem[{page, 8'(i)}], chkData: 1'b1};
      expQ.push_back(c);
    end
  endtask

  // Reference model: each clock consumes one expected DMA cycle, or starts a
  // transfer when idle and the CPU writes the DMA register.
  always @(posedge clk_ph1 or posedge rst) begin
    if (rst) begin
      expQ.delete();
      modelCycle = 0;
    end else begin
      modelCycle++;
      if (expQ.size() > 0) void'(expQ.pop_front());
      else if (cpu_r_nw == 1'b0 && cpu_addr == 16'h4014) buildTransfer(cpu_dout, modelCycle % 2);
    end
  end

  // Compare process: every cycle, mid-cycle, against the model.
  always @(negedge clk_ph1) begin
    if (expQ.size() > 0) begin
      checkOutput("dma_bus_addr", bus_addr, expQ[0].addr);
      checkOutput("dma_bus_r_nw", bus_r_nw, expQ[0].rnw);
      if (expQ[0].chkData) checkOutput("dma_bus_dout", bus_dout, expQ[0].data);
      checkOutput("dma_cpu_rdy", cpu_rdy, 1'b0);
      checkOutput("dma_active_hi", dma_active, 1'b1);
    end else begin
      checkOutput("idle_bus_addr", bus_addr, cpu_addr);
      checkOutput("idle_bus_dout", bus_dout, cpu_dout);
      checkOutput("idle_bus_r_nw", bus_r_nw, cpu_r_nw);
      checkOutput("idle_cpu_rdy", cpu_rdy, 1'b1);
      checkOutput("idle_active_lo", dma_active, 1'b0);
    end
    if (cpu_rdy === 1'b0) lowRun++;
    else if (lowRun > 0) begin
      lastStall = lowRun;
      lowRun = 0;
    end
    if (dma_active === 1'b1 && bus_r_nw === 1'b0 && bus_addr === 16'h2004) oamLog.push_back(bus_dout);
    if (dma_active === 1'b1 && bus_r_nw === 1'b1 && bus_addr[7:0] === 8'h00) page00Reads++;
  end

  task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] data, input logic rnw);
    @(posedge clk_ph1);
    #2;
    cpu_addr = addr;
    cpu_dout = data;
    cpu_r_nw = rnw;
  endtask

  task automatic idleTraffic(input int cycles);
    logic [15:0] a;
    logic        rnw;
    for (int i = 0; i < cycles; i++) begin
      a   = 16'($urandom);
      rnw = 1'($urandom_range(0, 1));
      if (!rnw && a == 16'h4014) a = 16'h4015;
      applyStimulus(a, 8'($urandom), rnw);
    end
  endtask

  // Issue the trigger write in a cycle whose parity puts HALT on a put cycle
  // (haltOnPut) or on a get cycle.
  task automatic triggerDma(input logic [7:0] page, input bit haltOnPut);
    oamLog.delete();
    page00Reads = 0;
    do begin
      @(posedge clk_ph1);
      #2;
    end while ((modelCycle % 2) != (haltOnPut ? 0 : 1));
    cpu_addr = 16'h4014;
    cpu_dout = page;
    cpu_r_nw = 1'b0;
    applyStimulus(16'h8000, 8'h00, 1'b1);
  endtask

  // Stalled CPU keeps hammering $4014 for a while; those writes must be ignored.
  task automatic runToIdle();
    int n = 0;
    do begin
      @(posedge clk_ph1);
      #2;
      if (n < 20) begin
        cpu_addr = 16'h4014;
        cpu_dout = 8'($urandom);
        cpu_r_nw = 1'b0;
      end else begin
        cpu_addr = 16'($urandom);
        cpu_dout = 8'($urandom);
        cpu_r_nw = 1'b1;
      end
      n++;
    end while (cpu_rdy !== 1'b1 && n < 1000);
    if (cpu_rdy !== 1'b1) begin
      vectorCount++;
      missCount++;
      $display("[TB] FAIL dma_timeout: cpu_rdy %0b after %0d cycles, expected 1", cpu_rdy, n);
    end
    @(negedge clk_ph1);
    #1;
  endtask

  initial begin
    logic [7:0] page;
    bit         onPut;
    int         n;

    for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
    for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;

    rst      = 1'b1;
    cpu_addr = 16'h8000;
    cpu_dout = 8'h00;
    cpu_r_nw = 1'b1;
    repeat (3) @(posedge clk_ph1);
    #2;
    checkOutput("rst_bus_addr", bus_addr, 16'h8000);
    checkOutput("rst_bus_r_nw", bus_r_nw, 1'b1);
    checkOutput("rst_cpu_rdy", cpu_rdy, 1'b1);
    checkOutput("rst_dma_active", dma_active, 1'b0);
    rst = 1'b0;
    idleTraffic(30);

    $display("[TB] page $02, HALT on put cycle");
    triggerDma(8'h02, 1'b1);
    runToIdle();
    checkOutput("put_stall_len", lastStall, 513);
    checkOutput("put_write_count", oamLog.size(), 256);
    checkOutput("put_first_data", oamLog[0], 8'h5A);
    checkOutput("put_second_data", oamLog[1], 8'h5B);
    checkOutput("put_last_data", oamLog[255], 8'hA5);
    checkOutput("put_page00_reads", page00Reads, 2);
    idleTraffic(10);

    $display("[TB] page $02, HALT on get cycle");
    triggerDma(8'h02, 1'b0);
    runToIdle();
    checkOutput("get_stall_len", lastStall, 514);
    checkOutput("get_write_count", oamLog.size(), 256);
    checkOutput("get_first_data", oamLog[0], 8'h5A);
    checkOutput("get_page00_reads", page00Reads, 3);
    idleTraffic(10);

    $display("[TB] page $FF");
    triggerDma(8'hFF, 1'b1);
    runToIdle();
    checkOutput("ff_write_count", oamLog.size(), 256);
    checkOutput("ff_first_data", oamLog[0], mem[16'hFF00]);
    checkOutput("ff_last_data", oamLog[255], mem[16'hFFFF]);
    idleTraffic(20);

    $display("[TB] reset during 100th OAM write");
    triggerDma(8'h02, 1'($urandom_range(0, 1)));
    n = 0;
    while (oamLog.size() < 100 && n < 1000) begin
      @(negedge clk_ph1);
      #1;
      n++;
    end
    checkOutput("rst_mid_reached", oamLog.size(), 100);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_cpu_rdy", cpu_rdy, 1'b1);
    checkOutput("rst_mid_active", dma_active, 1'b0);
    @(posedge clk_ph1);
    #2;
    rst = 1'b0;
    applyStimulus(16'h8000, 8'h00, 1'b1);
    idleTraffic(10);
    checkOutput("rst_no_more_writes", oamLog.size(), 100);
    triggerDma(8'h02, 1'b1);
    runToIdle();
    checkOutput("restart_write_count", oamLog.size(), 256);
    checkOutput("restart_first_data", oamLog[0], 8'h5A);
    checkOutput("restart_stall_len", lastStall, 513);

    $display("[TB] non-trigger accesses");
    applyStimulus(16'h4015, 8'h03, 1'b0);
    applyStimulus(16'h4014, 8'h03, 1'b1);
    applyStimulus(16'h8000, 8'h00, 1'b1);
    @(negedge clk_ph1);
    #1;
    checkOutput("no_trigger_rdy", cpu_rdy, 1'b1);
    checkOutput("no_trigger_active", dma_active, 1'b0);

    $display("[TB] random transfers");
    for (int t = 0; t < 3; t++) begin
      idleTraffic(int'($urandom_range(3, 25)));
      page  = 8'($urandom);
      onPut = 1'($urandom_range(0, 1));
      triggerDma(page, onPut);
      runToIdle();
      checkOutput("rand_stall_len", lastStall, onPut ? 513 : 514);
      checkOutput("rand_write_count", oamLog.size(), 256);
      checkOutput("rand_last_data", oamLog[255], mem[{page, 8'hFF}]);
    end
    idleTraffic(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
